// File: rtl/coord_mem_arbiter.sv
// rtl/coord_mem_arbiter.sv - round-robin arbiter sharing the x/y coordinate RAM pair
// Optional owner lock feature: define COORD_ARB_LOCK_EN.
module coord_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_x,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_y,
`ifdef COORD_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          lock,
`endif
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata_x,
  output logic [DATA_W-1:0]           rdata_y,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_wren,
  output logic [DATA_W-1:0]           mem_x_d,
  output logic [DATA_W-1:0]           mem_y_d,
  input  logic [DATA_W-1:0]           mem_x_q,
  input  logic [DATA_W-1:0]           mem_y_q
);

  localparam int OW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_RESP = 2'd3
  } state_t;

  state_t             r_state;
  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      r_last_owner;
  logic               r_we;
`ifdef COORD_ARB_LOCK_EN
  logic               r_lock_armed;
`endif

  logic               w_win_found;
  logic [OW-1:0]      w_win;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_owner_oh;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    w_win_found = 1'b0;
    w_win       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_win_found && req[(int'(r_last_owner) + k) % NUM_REQ]) begin
        w_win_found = 1'b1;
        w_win       = OW'((int'(r_last_owner) + k) % NUM_REQ);
      end
    end
`ifdef COORD_ARB_LOCK_EN
    if (r_lock_armed && lock[r_last_owner] && req[r_last_owner]) begin
      w_win = r_last_owner;
    end
`endif
  end

  always_comb begin
    w_win_oh   = '0;
    w_owner_oh = '0;
    w_win_oh[w_win]     = 1'b1;
    w_owner_oh[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
      r_we         <= 1'b0;
`ifdef COORD_ARB_LOCK_EN
      r_lock_armed <= 1'b0;
`endif
      gnt          <= '0;
      rvalid       <= '0;
      busy         <= 1'b0;
      mem_wren     <= 1'b0;
      mem_addr     <= '0;
      mem_x_d      <= '0;
      mem_y_d      <= '0;
      rdata_x      <= '0;
      rdata_y      <= '0;
    end else begin
      gnt      <= '0;
      rvalid   <= '0;
      mem_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_state      <= S_ISSUE;
            r_owner      <= w_win;
            r_last_owner <= w_win;
            r_we         <= we[w_win];
`ifdef COORD_ARB_LOCK_EN
            r_lock_armed <= 1'b1;
`endif
            gnt          <= w_win_oh;
            busy         <= 1'b1;
            mem_wren     <= we[w_win];
            mem_addr     <= addr[w_win*ADDR_W +: ADDR_W];
            mem_x_d      <= wdata_x[w_win*DATA_W +: DATA_W];
            mem_y_d      <= wdata_y[w_win*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        // RAM output is valid now, one cycle after the address was presented.
        S_RD_WAIT: begin
          r_state <= S_RD_RESP;
          rdata_x <= mem_x_q;
          rdata_y <= mem_y_q;
          rvalid  <= w_owner_oh;
        end
        S_RD_RESP: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/coord_mem_arbiter.md
# coord_mem_arbiter

Shares the single-port x/y coordinate RAM pair between several requesters: the coordinate collector (writes), the pathfinding engine (reads) and the display/readback path (reads). It runs a round-robin arbiter and a small access state machine, and latches each winner's command. It drives one RAM access at a time and returns read data to the owning requester with a one-cycle valid pulse. It sits between the requester blocks and the x/y coordinate RAMs, which are synchronous-read with one-cycle latency and a shared address/write-enable.

## Interface
- NUM_REQ, 3: number of requesters, 2..4.
- ADDR_W, 8: coordinate RAM address width.
- DATA_W, 8: width of each of the x and y words.

- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req  input  NUM_REQ  request, one bit per requester; held high until gnt
- we  input  NUM_REQ  1 = write, 0 = read; qualified by req
- addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- wdata_x, wdata_y  input  NUM_REQ*DATA_W  packed write data
- gnt  output  NUM_REQ  one-hot single-cycle pulse; command accepted
- rvalid  output  NUM_REQ  one-hot single-cycle pulse; rdata valid for that requester
- rdata_x, rdata_y  output  DATA_W  read data, shared by all requesters, held until the next read response
- busy  output  1  high in every state except IDLE
- mem_addr  output  ADDR_W  RAM address
- mem_wren  output  1  RAM write enable, asserted for the x and y RAMs together
- mem_x_d, mem_y_d  output  DATA_W  RAM write data
- mem_x_q, mem_y_q  input  DATA_W  RAM read data; valid the cycle after the address is presented

## Operation
- States:
  - IDLE: the arbiter evaluates req.
  - ISSUE: the latched command is driven to the RAM and gnt[owner] is high.
  - RD_WAIT: the RAM outputs are captured into rdata_x/rdata_y.
  - RD_RESP: rvalid[owner] is high.
- Transitions: IDLE→ISSUE if any req; ISSUE→IDLE on a write; ISSUE→RD_WAIT on a read; RD_WAIT→RD_RESP; RD_RESP→IDLE.
- Arbitration in IDLE:
  - Search starts at the requester after last_owner and wraps modulo NUM_REQ; the first set req bit wins.
  - owner, we, addr and wdata of the winner are latched on the IDLE→ISSUE edge.
  - last_owner updates to the winner on the same edge.
- req is sampled only in IDLE. A requester may drop req and change addr/wdata from the cycle after its gnt.
- mem_addr, mem_wren, mem_x_d and mem_y_d are registered and reflect the latched command only during ISSUE.
- Outside ISSUE: mem_wren = 0; mem_addr and mem_x_d/mem_y_d hold their last values.
- A write and a read to the same address, granted back to back, are ordered by grant, so the read returns the new data.

## Timing
- Reset values:
  - state = IDLE; last_owner = NUM_REQ-1, so requester 0 wins first.
  - gnt = 0, rvalid = 0, busy = 0, mem_wren = 0.
  - mem_addr = 0, mem_x_d = 0, mem_y_d = 0, rdata_x = 0, rdata_y = 0.
- Write: req high at cycle 0 in IDLE → gnt and mem_wren high in cycle 1 → IDLE in cycle 2. Two cycles per write.
- Read: gnt in cycle 1, capture in cycle 2, rvalid in cycle 3, IDLE in cycle 4. Four cycles per read.
- Two requesters continuously requesting alternate in round-robin order; neither starves.
- All req bits low in IDLE: the block stays in IDLE with no outputs asserted.
- Reset asserted mid-operation: immediate return to reset values. No pending gnt or rvalid is produced after reset releases, and the in-flight read is discarded.
- A requester's req bit is ignored while another requester owns the bus.

## Configuration
- COORD_ARB_LOCK_EN defined:
  - Adds input lock[NUM_REQ-1:0].
  - If lock[owner] and req[owner] are both high in IDLE after that owner's access, the same owner wins again regardless of round-robin; last_owner is unchanged.
  - This gives the collector an uninterrupted burst of writes.
- COORD_ARB_LOCK_EN undefined: the lock port does not exist and arbitration is pure round-robin.

## Test plan
- After reset, requester 0 writes addr 0x05, x=0x12, y=0x34 → gnt[0] and mem_wren high in cycle 1 with mem_addr=0x05; busy low in cycle 2.
- Requester 1 reads addr 0x05 with the RAM model holding 0x12/0x34 → gnt[1] in cycle 1; rvalid[1] in cycle 3 with rdata_x=0x12, rdata_y=0x34.
- All three requesters request continuously → grant order 0,1,2,0,1,2; no requester waits more than 2 accesses.
- Reset pulse during RD_WAIT → all outputs return to reset values and no rvalid appears within 10 cycles after release.
- Requester 0 writes 0x07 to addr 0x10 while requester 2 has a read of addr 0x10 pending → the write is granted first and the read returns x=0x07.
- With COORD_ARB_LOCK_EN, lock[0]=1 and req[0]=req[1]=1 for 4 accesses → four consecutive gnt[0]; when lock drops, the next grant goes to requester 1.
